// File: rtl/iiitb_uart_rx_pkg.sv
// iiitb_uart_rx_pkg: UART state encodings and defaults shared by the receive and transmit ends
package iiitb_uart_rx_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 217;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;
endpackage

// File: rtl/iiitb_uart_sync.sv
// iiitb_uart_sync: two-flop synchroniser; presets to 1 so an idle-high line reads idle through reset
module iiitb_uart_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);
  logic meta;
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) {o_Sync, meta} <= 2'b11;
    else {o_Sync, meta} <= {meta, i_Async};
endmodule

// File: rtl/iiitb_uart_rx.sv
// iiitb_uart_rx: 8N1 UART receiver; qualifies the start bit at half a bit, then samples mid-bit
module iiitb_uart_rx
  import iiitb_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err
);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
  state_t state, state_n;
  logic [15:0] clk_cnt, cnt_n;
  logic [2:0] bit_idx, idx_n;
  logic [7:0] shift_reg, shift_n, byte_n;
  logic dv_n, err_n, rx_s;
  iiitb_uart_sync u_sync (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_Async(i_RX_Serial),
    .o_Sync (rx_s)
  );
  assign o_RX_Active = state != IDLE;
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      state          <= IDLE;
      clk_cnt        <= '0;
      bit_idx        <= '0;
      shift_reg      <= '0;
      o_RX_Byte      <= '0;
      o_RX_DV        <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
    end else begin
      state          <= state_n;
      clk_cnt        <= cnt_n;
      bit_idx        <= idx_n;
      shift_reg      <= shift_n;
      o_RX_Byte      <= byte_n;
      o_RX_DV        <= dv_n;
      o_RX_Frame_Err <= err_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = clk_cnt + 16'd1;
    idx_n   = bit_idx;
    shift_n = shift_reg;
    byte_n  = o_RX_Byte;
    dv_n    = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!rx_s) state_n = START;
      end
      START:
        if (clk_cnt == HALF) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      DATA:
        if (clk_cnt == LAST) begin
          cnt_n            = '0;
          shift_n[bit_idx] = rx_s;
          idx_n            = bit_idx + 3'd1;
          if (bit_idx == LAST_BIT) state_n = STOP;
        end
      STOP:
        if (clk_cnt == LAST) begin
          cnt_n   = '0;
          state_n = CLEANUP;
          dv_n    = rx_s;
          err_n   = !rx_s;
          if (rx_s) byte_n = shift_reg;
        end
      CLEANUP: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end
endmodule
